// File: rtl/axi4_burst_beat_gen_if.sv
// axi4_burst_beat_gen_if: command and beat channels of the burst beat generator
interface axi4_burst_beat_gen_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int STROBE_WIDTH  = 4,
  parameter int ID_WIDTH      = 4
);
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [ID_WIDTH-1:0]      cmd_id;
  logic [ADDRESS_WIDTH-1:0] cmd_addr;
  logic [7:0]               cmd_len;
  logic [2:0]               cmd_size;
  logic [1:0]               cmd_burst;
  logic                     beat_valid;
  logic                     beat_ready;
  logic [ADDRESS_WIDTH-1:0] beat_addr;
  logic [STROBE_WIDTH-1:0]  beat_strb;
  logic [ID_WIDTH-1:0]      beat_id;
  logic [7:0]               beat_idx;
  logic                     beat_last;
  logic                     beat_err;
  modport slave (
    input  cmd_valid, cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst, beat_ready,
    output cmd_ready, beat_valid, beat_addr, beat_strb, beat_id, beat_idx, beat_last, beat_err
  );
  modport master (
    output cmd_valid, cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst, beat_ready,
    input  cmd_ready, beat_valid, beat_addr, beat_strb, beat_id, beat_idx, beat_last, beat_err
  );
endinterface

// File: rtl/axi4_burst_beat_gen.sv
// axi4_burst_beat_gen: queues AXI4 address commands and expands each into per-beat address/strobe/last
module axi4_burst_beat_gen #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int STROBE_WIDTH  = DATA_WIDTH / 8,
  parameter int ID_WIDTH      = 4,
  parameter int CMD_DEPTH     = 4
) (
  input  logic aclk,
  input  logic areset,
  axi4_burst_beat_gen_if.slave bus,
  output logic busy
);
  localparam int PW = $clog2(CMD_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [2:0] SW_LOG = 3'($clog2(STROBE_WIDTH));
  localparam logic [ADDRESS_WIDTH-1:0] SMASK = ADDRESS_WIDTH'(STROBE_WIDTH - 1);
  typedef struct packed {
    logic [ID_WIDTH-1:0]      id;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [7:0]               len;
    logic [2:0]               size;
    logic [1:0]               burst;
  } cmd_t;
  typedef enum logic [1:0] {IDLE, LOAD, BURST} state_t;
  state_t state, nxt;
  cmd_t fifo [CMD_DEPTH];
  cmd_t c;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count, count_nxt;
  logic push, pop, nonempty, valid, hs, last, err;
  logic [ADDRESS_WIDTH-1:0] cur, n, c_mask, tot, w_mask, last_byte, nxt_addr, lo, hi;
  logic [7:0] idx;
  logic [STROBE_WIDTH-1:0] strb;
  assign push      = bus.cmd_valid && bus.cmd_ready;
  assign nonempty  = count != '0;
  assign valid     = state == BURST;
  assign hs        = valid && bus.beat_ready;
  assign last      = idx == c.len;
  assign pop       = nonempty && (state == IDLE || (hs && last));
  assign count_nxt = count + CW'(push) - CW'(pop);
  assign busy      = nonempty || state != IDLE;
  always_comb begin
    n         = ADDRESS_WIDTH'(1) << c.size;
    c_mask    = n - ADDRESS_WIDTH'(1);
    tot       = (ADDRESS_WIDTH'(c.len) + ADDRESS_WIDTH'(1)) << c.size;
    w_mask    = tot - ADDRESS_WIDTH'(1);
    last_byte = (c.addr & ~c_mask) + w_mask;
    err = c.burst == 2'b11 || c.size > SW_LOG
       || (c.burst == 2'b10 && (!(c.len inside {8'd1, 8'd3, 8'd7, 8'd15}) || (c.addr & c_mask) != '0))
       || (c.burst == 2'b00 && c.len > 8'd15)
       || (c.burst == 2'b01 && ((last_byte ^ c.addr) >> 12) != '0);
    // wrap windows are power-of-two aligned, so wrapping is just keeping the low bits of cur+N
    nxt_addr = err || c.burst == 2'b00 ? cur
             : c.burst == 2'b01 ? (cur & ~c_mask) + n
             : (cur & ~w_mask) | ((cur + n) & w_mask);
    lo = cur & SMASK;
    hi = ((cur & ~c_mask) & SMASK) + c_mask;
    strb = '0;
    for (int i = 0; i < STROBE_WIDTH; i++) strb[i] = !err && ADDRESS_WIDTH'(i) >= lo && ADDRESS_WIDTH'(i) <= hi;
    nxt = state == IDLE  ? (nonempty ? LOAD : IDLE)
        : state == LOAD  ? BURST
        : state == BURST ? (hs && last ? (nonempty ? LOAD : IDLE) : BURST)
        : IDLE;
  end
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      state         <= IDLE;
      count         <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      bus.cmd_ready <= 1'b0;
      c             <= '0;
      cur           <= '0;
      idx           <= '0;
    end else begin
      state         <= nxt;
      count         <= count_nxt;
      bus.cmd_ready <= count_nxt != CW'(CMD_DEPTH);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        c      <= fifo[rd_ptr];
        cur    <= fifo[rd_ptr].addr;
        idx    <= '0;
      end else if (hs && !last) begin
        cur <= nxt_addr;
        idx <= idx + 8'd1;
      end
    end
  always_ff @(posedge aclk)
    if (push) fifo[wr_ptr] <= {bus.cmd_id, bus.cmd_addr, bus.cmd_len, bus.cmd_size, bus.cmd_burst};
  assign bus.beat_valid = valid;
  assign bus.beat_addr  = valid ? cur : '0;
  assign bus.beat_strb  = valid ? strb : '0;
  assign bus.beat_id    = valid ? c.id : '0;
  assign bus.beat_idx   = valid ? idx : '0;
  assign bus.beat_last  = valid && last;
  assign bus.beat_err   = valid && err;
endmodule

// File: tb/tb_axi4_burst_beat_gen.sv
// tb_axi4_burst_beat_gen: random and directed commands checked against a burst-level reference model
module tb_axi4_burst_beat_gen;
  localparam int AW = 32, DW = 32, SW = DW / 8, IW = 4, DEPTH = 4;
  logic aclk = 1'b0, areset = 1'b1, busy;
  axi4_burst_beat_gen_if #(.ADDRESS_WIDTH(AW), .STROBE_WIDTH(SW), .ID_WIDTH(IW)) bus();
  axi4_burst_beat_gen #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .CMD_DEPTH(DEPTH)) dut (
    .aclk(aclk), .areset(areset), .bus(bus), .busy(busy));
  always #5 aclk = ~aclk;
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [SW-1:0] strb;
    logic [IW-1:0] id;
    logic [7:0]    idx;
    logic          last;
    logic          err;
  } beat_t;
  beat_t exp_q[$];
  int acc_q[$];
  int n_checks = 0, n_fail = 0, cyc = 0, start_edge = 0, last_end = -1000, br_mode = 2;
  bit act = 1'b0;
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask
  // beat k of a command, straight from the address/strobe/error rules
  function automatic beat_t model_beat(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                                       input logic [2:0] size, input logic [1:0] burst, input int k);
    longint n = longint'(1) << size;
    longint a = longint'(addr);
    longint al = a - (a % n);
    longint w = n * (longint'(len) + 1);
    longint lower = a - (a % w);
    longint last_byte = (al + w - 1) % (longint'(1) << AW);
    longint cur = a;
    beat_t b;
    bit err;
    err = burst == 3 || n > SW
       || (burst == 2 && (!(len == 1 || len == 3 || len == 7 || len == 15) || a % n != 0))
       || (burst == 0 && len > 15)
       || (burst == 1 && last_byte / 4096 != a / 4096);
    if (!err && burst == 1 && k > 0) cur = (al + k * n) % (longint'(1) << AW);
    if (!err && burst == 2)
      for (int j = 0; j < k; j++) begin
        cur = cur + n;
        if (cur >= lower + w) cur = lower;
      end
    b.addr = AW'(cur);
    b.id   = id;
    b.idx  = 8'(k);
    b.last = k == int'(len);
    b.err  = err;
    b.strb = '0;
    for (int l = 0; l < SW; l++)
      if (!err && l >= cur % SW && l <= (cur - cur % n) % SW + n - 1) b.strb[l] = 1'b1;
    return b;
  endfunction
  always @(posedge aclk) cyc++;
  always @(posedge aclk) begin
    #1;
    if (br_mode == 0) bus.beat_ready = 1'($urandom_range(0, 1));
    else if (br_mode == 1) bus.beat_ready = 1'b0;
    else if (br_mode == 2) bus.beat_ready = 1'b1;
  end
  // burst start edge: one LOAD bubble after the previous last beat if the command was already queued, else accept+2
  task automatic try_start();
    if (!act && acc_q.size() > 0) begin
      int a = acc_q.pop_front();
      start_edge = a < last_end ? last_end + 1 : (a > last_end ? a : last_end) + 2;
      act = 1'b1;
    end
  endtask
  always @(negedge aclk) begin
    beat_t b;
    if (areset) begin
      chk("reset_outputs", {bus.beat_valid, bus.cmd_ready, busy}, 0);
      exp_q.delete();
      acc_q.delete();
      act = 1'b0;
      last_end = -1000;
    end else begin
      try_start();
      chk("beat_valid", bus.beat_valid, act && cyc >= start_edge);
      if (bus.beat_valid && act && cyc >= start_edge && exp_q.size() > 0) begin
        chk("beat", {bus.beat_addr, bus.beat_strb, bus.beat_id, bus.beat_idx, bus.beat_last, bus.beat_err}, exp_q[0]);
        if (bus.beat_ready) begin
          b = exp_q.pop_front();
          if (b.last) begin
            act = 1'b0;
            last_end = cyc + 1;
            try_start();
          end
        end
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        for (int k = 0; k <= int'(bus.cmd_len); k++)
          exp_q.push_back(model_beat(bus.cmd_id, bus.cmd_addr, bus.cmd_len, bus.cmd_size, bus.cmd_burst, k));
        acc_q.push_back(cyc + 1);
      end
    end
  end
  task automatic set_cmd(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    bus.cmd_id = id; bus.cmd_addr = addr; bus.cmd_len = len; bus.cmd_size = size; bus.cmd_burst = burst;
  endtask
  task automatic send(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                      input logic [2:0] size, input logic [1:0] burst);
    bit ok = 1'b0;
    @(posedge aclk); #1;
    set_cmd(id, addr, len, size, burst);
    bus.cmd_valid = 1'b1;
    for (int t = 0; t < 3000 && !ok; t++) begin
      @(negedge aclk); ok = bus.cmd_ready;
      @(posedge aclk); #1;
    end
    bus.cmd_valid = 1'b0;
    chk("cmd_accept_timeout", ok, 1);
  endtask
  task automatic wait_idle();
    bit done = 1'b0;
    for (int t = 0; t < 6000 && !done; t++) begin
      @(negedge aclk); #1;
      done = !busy && !act && exp_q.size() == 0;
    end
    chk("idle_timeout", done, 1);
  endtask
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end
  initial begin
    beat_t b;
    int acc, idx;
    bit ok, saw_valid;
    logic [1:0] bu;
    logic [2:0] sz;
    logic [7:0] ln;
    logic [AW-1:0] ad;
    bus.cmd_valid = 1'b0; bus.beat_ready = 1'b0;
    set_cmd('0, '0, '0, '0, '0);
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("reset_cmd_ready", bus.cmd_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_beat_addr", bus.beat_addr, 0);
    b = model_beat(1, 32'h1002, 3, 2, 1, 0); chk("pin_incr_b0", {b.addr, b.strb, b.last, b.err}, {32'h1002, 4'b1100, 1'b0, 1'b0});
    b = model_beat(1, 32'h1002, 3, 2, 1, 1); chk("pin_incr_b1", {b.addr, b.strb, b.last, b.err}, {32'h1004, 4'b1111, 1'b0, 1'b0});
    b = model_beat(1, 32'h1002, 3, 2, 1, 3); chk("pin_incr_b3", {b.addr, b.strb, b.last, b.err}, {32'h100C, 4'b1111, 1'b1, 1'b0});
    b = model_beat(2, 32'h1008, 3, 2, 2, 2); chk("pin_wrap_b2", {b.addr, b.strb, b.last}, {32'h1000, 4'b1111, 1'b0});
    b = model_beat(2, 32'h1008, 3, 2, 2, 3); chk("pin_wrap_b3", {b.addr, b.strb, b.last}, {32'h1004, 4'b1111, 1'b1});
    b = model_beat(3, 32'h1003, 2, 0, 0, 2); chk("pin_fixed_b2", {b.addr, b.strb, b.idx, b.last}, {32'h1003, 4'b1000, 8'd2, 1'b1});
    b = model_beat(4, 32'h0FF8, 3, 2, 1, 1); chk("pin_page_err", {b.addr, b.strb, b.last, b.err}, {32'h0FF8, 4'b0000, 1'b0, 1'b1});
    b = model_beat(5, 32'h4000, 0, 0, 3, 0); chk("pin_reserved", {b.strb, b.last, b.err}, {4'b0000, 1'b1, 1'b1});
    @(posedge aclk); #1 areset = 1'b0;
    @(negedge aclk); chk("cmd_ready_before_edge", bus.cmd_ready, 0);
    @(negedge aclk); chk("cmd_ready_after_release", bus.cmd_ready, 1);
    br_mode = 2;
    send(1, 32'h1002, 3, 2, 1); wait_idle();
    send(2, 32'h1008, 3, 2, 2); wait_idle();
    send(3, 32'h1003, 2, 0, 0); wait_idle();
    send(4, 32'h0FF8, 3, 2, 1); wait_idle();
    send(5, 32'h4000, 0, 0, 3); wait_idle();
    br_mode = 1; acc = 0; idx = 0;
    @(posedge aclk); #1;
    set_cmd(4'(idx), 32'h3000 + 32'h100 * idx, 1, 2, 1);
    bus.cmd_valid = 1'b1;
    repeat (20) begin
      @(negedge aclk); ok = bus.cmd_ready;
      @(posedge aclk); #1;
      if (ok && bus.cmd_valid) begin
        acc++; idx++;
        if (idx < 7) set_cmd(4'(idx), 32'h3000 + 32'h100 * idx, 1, 2, 1);
        else bus.cmd_valid = 1'b0;
      end
    end
    bus.cmd_valid = 1'b0;
    chk("bp_accepted", acc, 5);
    @(negedge aclk);
    chk("bp_cmd_ready", bus.cmd_ready, 0);
    chk("bp_busy", busy, 1);
    br_mode = 2;
    wait_idle();
    br_mode = 0;
    for (int r = 0; r < 300; r++) begin
      bu = ($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      ln = (bu == 2 && $urandom_range(0, 7) != 0) ? 8'((1 << $urandom_range(1, 4)) - 1)
         : ($urandom_range(0, 9) == 0 ? 8'($urandom_range(16, 40)) : 8'($urandom_range(0, 15)));
      ad = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 15)) * 32'h1000 - 32'($urandom_range(0, 64)) : 32'($urandom);
      if (bu == 2 && $urandom_range(0, 7) != 0) ad = ad & ~((32'd1 << sz) - 32'd1);
      send(4'($urandom), ad, ln, sz, bu);
      repeat ($urandom_range(0, 3)) @(posedge aclk);
    end
    br_mode = 2;
    wait_idle();
    br_mode = 3; bus.beat_ready = 1'b0;
    send(9, 32'h2000, 7, 2, 1);
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin @(negedge aclk); ok = bus.beat_valid; end
    chk("mid_first_beat", ok, 1);
    @(posedge aclk); #1 bus.beat_ready = 1'b1;
    @(posedge aclk); #1 bus.beat_ready = 1'b0;
    send(10, 32'h5000, 3, 2, 1);
    send(11, 32'h6000, 3, 2, 1);
    @(negedge aclk);
    chk("mid_beat_idx", bus.beat_idx, 1);
    @(posedge aclk); #1 areset = 1'b1;
    #1;
    chk("async_beat_valid", bus.beat_valid, 0);
    chk("async_busy", busy, 0);
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;
    br_mode = 2; saw_valid = 1'b0;
    repeat (30) begin @(negedge aclk); if (bus.beat_valid) saw_valid = 1'b1; end
    chk("post_reset_no_beats", saw_valid, 0);
    chk("post_reset_busy", busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
